// File: rtl/ex_simd_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_simd_div
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU, with LANES
//               lock-step W-bit lanes and a one-cycle divide-by-zero/overflow path.
// Revision    : 1.0  initial release
// ============================================================================
module ex_simd_div #(
    parameter int W     = 32,
    parameter int LANES = 2,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic                 simd_en,
    input  logic [LANES*W-1:0]   s1,
    input  logic [LANES*W-1:0]   s2,
    output logic                 busy,
    output logic                 out_ready,
    output logic [LANES*W-1:0]   result,
    output logic [LANES-1:0]     dz_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_rem_sel;
    logic             r_simd;

    logic             w_accept;
    logic             w_fast;
    logic             w_step;
    logic             w_last;
    logic [LANES-1:0] w_active_in;
    logic [LANES-1:0] w_special;

    assign w_accept  = (r_state == S_IDLE) && in_valid && !flush;
    // Lanes that are inactive never hold the request on the slow path.
    assign w_fast    = &(w_special | ~w_active_in);
    assign w_step    = (r_state == S_BUSY) && !flush;
    assign w_last    = w_step && (r_cnt == CNT_W'(1));
    assign busy      = r_busy;
    assign out_ready = (r_state == S_DONE) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_rem_sel <= 1'b0;
            r_simd    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= op[1];
                        r_simd    <= simd_en;
                        r_busy    <= 1'b1;
                        if (w_fast) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_W'(W);
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam bit c_lane0 = (i == 0);

        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        logic         w_signed;
        logic         w_neg_a;
        logic         w_neg_b;
        logic [W-1:0] w_a_abs;
        logic [W-1:0] w_b_abs;
        logic         w_dz;
        logic         w_ovf;
        logic [W-1:0] w_fast_res;
        logic [W:0]   w_rem_sh;
        logic [W:0]   w_diff;
        logic [W-1:0] w_quo_nx;
        logic [W-1:0] w_rem_nx;
        logic [W-1:0] w_q_fin;
        logic [W-1:0] w_r_fin;
        logic         w_act;

        logic [W-1:0] r_quo;
        logic [W-1:0] r_rem;
        logic [W-1:0] r_dvs;
        logic         r_q_neg;
        logic         r_r_neg;
        logic         r_dz;
        logic [W-1:0] r_res;
        logic         r_dzf;

        assign w_a      = s1[i*W +: W];
        assign w_b      = s2[i*W +: W];
        assign w_signed = ~op[0];
        assign w_neg_a  = w_signed & w_a[W-1];
        assign w_neg_b  = w_signed & w_b[W-1];
        assign w_a_abs  = w_neg_a ? -w_a : w_a;
        assign w_b_abs  = w_neg_b ? -w_b : w_b;
        assign w_dz     = (w_b == '0);
        assign w_ovf    = w_signed && (w_a == {1'b1, {(W-1){1'b0}}}) && (w_b == '1);

        assign w_active_in[i] = c_lane0 | simd_en;
        assign w_special[i]   = w_dz | w_ovf;

        // Only dz or overflow lanes reach the fast path, so two cases suffice.
        assign w_fast_res = op[1] ? (w_dz ? w_a : '0) : (w_dz ? '1 : w_a);

        // Restoring step: the dividend shifts out of r_quo into the partial remainder.
        assign w_rem_sh = {r_rem, r_quo[W-1]};
        assign w_diff   = w_rem_sh - {1'b0, r_dvs};
        assign w_quo_nx = {r_quo[W-2:0], ~w_diff[W]};
        assign w_rem_nx = w_diff[W] ? w_rem_sh[W-1:0] : w_diff[W-1:0];

        // With a zero divisor the remainder path already reproduces the dividend.
        assign w_q_fin = r_dz ? '1 : (r_q_neg ? -w_quo_nx : w_quo_nx);
        assign w_r_fin = r_r_neg ? -w_rem_nx : w_rem_nx;
        assign w_act   = c_lane0 | r_simd;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_quo   <= '0;
                r_rem   <= '0;
                r_dvs   <= '0;
                r_q_neg <= 1'b0;
                r_r_neg <= 1'b0;
                r_dz    <= 1'b0;
                r_res   <= '0;
                r_dzf   <= 1'b0;
            end else if (w_accept) begin
                r_quo   <= w_a_abs;
                r_rem   <= '0;
                r_dvs   <= w_b_abs;
                r_q_neg <= w_neg_a ^ w_neg_b;
                r_r_neg <= w_neg_a;
                r_dz    <= w_dz & w_active_in[i];
                if (w_fast) begin
                    r_res <= w_active_in[i] ? w_fast_res : '0;
                    r_dzf <= w_dz & w_active_in[i];
                end
            end else if (w_step && w_act) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                if (w_last) begin
                    r_res <= r_rem_sel ? w_r_fin : w_q_fin;
                    r_dzf <= r_dz;
                end
            end else if (w_last) begin
                r_res <= '0;
                r_dzf <= 1'b0;
            end
        end

        assign result[i*W +: W] = r_res;
        assign dz_flag[i]       = r_dzf;
    end

endmodule
`default_nettype wire

// File: doc/ex_simd_div.md
Name: ex_simd_div

Overview:
- Parametrised iterative integer divider for the EX stage. It serves RV32M/RV64M DIV, DIVU, REM and REMU in scalar mode, and packed divides in SIMD mode.
- Generalises the single-lane div_start/div_ready multi-cycle unit to LANES independent W-bit lanes that run in lock-step.
- Adds a one-cycle fast path for divide-by-zero and overflow, a flush input and per-lane divide-by-zero flags.
- The EX stage holds in_valid until out_ready, and drives its stall as in_valid && ~out_ready.

Parameters:
- W, 32, lane width in bits (power of two, at least 8).
- LANES, 2, number of lanes; total datapath is LANES*W bits.
- CNT_W, $clog2(W+1), iteration counter width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; abandons any operation in flight.
- in_valid  in  1  divide request; held high by EX until out_ready.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- simd_en  in  1  0: lane 0 only (scalar); 1: all lanes active.
- s1  in  LANES*W  dividends, lane i in bits [i*W +: W].
- s2  in  LANES*W  divisors, same packing as s1.
- busy  out  1  high in BUSY and DONE.
- out_ready  out  1  one-cycle pulse; result and dz_flag are valid in that cycle.
- result  out  LANES*W  quotient or remainder per lane; inactive lanes read 0.
- dz_flag  out  LANES  per-lane divide-by-zero indication, valid with out_ready.

Behaviour:
- Reset, asynchronous:
  - state returns to IDLE; counter is 0.
  - busy, out_ready, result and dz_flag are all 0.
  - Reset asserted mid-operation discards the operation with no out_ready.
- States:
  - IDLE: waits for a request.
  - BUSY: iterates one quotient bit per cycle.
  - DONE: presents the result.
- Accept rule: in IDLE with in_valid=1 and flush=0, the unit latches op, simd_en, |s1| and |s2| per lane, the sign of the quotient and the sign of the remainder. op[0]=1 means unsigned, so no absolute value is taken.
- Fast path (after accept):
  - If every active lane has divisor 0 or is signed overflow, go straight to DONE.
  - Signed overflow means DIV or REM with dividend 100..0 and divisor all-ones.
  - out_ready is then asserted in cycle T+1, where T is the accept cycle.
- Normal path (after accept):
  - Load counter with W and enter BUSY.
  - Each BUSY cycle performs one restoring shift-subtract step on every active lane and decrements the counter.
  - When the counter reaches 1, move to DONE.
  - out_ready is asserted in cycle T+W+1.
- DONE (exactly one cycle):
  - out_ready=1; result and dz_flag are driven from registers.
  - The next state is IDLE unconditionally, so a request is never re-accepted in the same cycle.
  - A new request can be accepted in the cycle after DONE.
- Per-lane results, following RISC-V semantics:
  - divisor 0: quotient all-ones, remainder = original dividend, dz_flag=1.
  - overflow: DIV result = dividend; REM result = 0.
  - otherwise: quotient negated if the signs differ; remainder takes the sign of the dividend.
- Inactive lanes (lanes 1..LANES-1 when simd_en=0): result 0, dz_flag 0. Their zero divisors do not block the fast path.
- Operand changes: s1, s2 and op are ignored after accept. EX holds them anyway.
- Flush:
  - In BUSY or DONE, the next state is IDLE and out_ready is 0 that cycle, including a flush arriving in the DONE cycle.
  - In IDLE, flush blocks acceptance.
  - Flush and reset have the same effect on state; reset additionally clears result.
- W=8 lanes still run W iterations. Latency depends only on W and the fast-path condition, never on operand values.

Test Plan (W=32, LANES=2):
- Scalar DIV: s1=-7, s2=2, op=00, accept at T -> out_ready at T+33, result[31:0]=-3, result[63:32]=0, dz_flag=00.
- Scalar REM: s1=-7, s2=2, op=10 -> remainder -1. REMU with s1=0xFFFFFFF9, s2=2 -> result 1.
- Divide-by-zero fast path: op=01, s1=0x1234, s2=0 -> out_ready at T+1, result 0xFFFFFFFF, dz_flag[0]=1. Same inputs with op=11 -> result 0x1234.
- SIMD mixed lanes: lane0 0x80000000/-1 (overflow), lane1 100/7, op=00 -> normal latency T+33, lane0=0x80000000, lane1=14. With op=10 -> lane0=0, lane1=2.
- Flush: flush pulse at T+10 -> no out_ready through T+40. A new request at T+12 completes at T+45.
- Reset mid-operation: rst asserted at T+5 -> busy=0 and result=0 immediately. After release, back-to-back requests are each accepted once, with one out_ready pulse per request.
